// File: rtl/cache_req_pkg.sv
// Shared types for the cache request master: FSM states, default widths and the request record.
package cache_req_pkg;

  localparam int unsigned DefAddrW = 2;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StCapt,
    StRsp
  } state_e;

  typedef struct packed {
    logic                write;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Small synchronous FIFO of request records; Depth must be a power of two.
module cache_req_fifo
  import cache_req_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  req_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cache_req_master.sv
// CPU-side initiator sequencing buffered read/write requests onto the cache pins.
// Define CACHE_REQ_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module cache_req_master
  import cache_req_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cache_wr_en,
  output logic              cache_rd_en,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data,
  input  logic [DATA_W-1:0] cache_out_data
);

  state_e            state_q, state_d;
  req_t              cur_q, cur_d;
  req_t              req_in, fifo_rdata;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              accept, bypass;

  assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  // An idle master with nothing buffered takes the request straight into cur_q.
  assign fifo_push = accept && !bypass;

  cache_req_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (req_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef CACHE_REQ_VERIFY_EN
  logic rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
    bypass      = 1'b0;
`ifdef CACHE_REQ_VERIFY_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_rdata;
          state_d  = fifo_rdata.write ? StWr : StRd;
        end else if (accept) begin
          bypass  = 1'b1;
          cur_d   = req_in;
          state_d = req_write ? StWr : StRd;
        end
      end
      StWr: begin
`ifdef CACHE_REQ_VERIFY_EN
        state_d = StRd;
`else
        rsp_rdata_d = cur_q.wdata;
        state_d     = StRsp;
`endif
      end
      StRd:   state_d = StCapt;
      StCapt: begin
        rsp_rdata_d = cache_out_data;
`ifdef CACHE_REQ_VERIFY_EN
        rsp_err_d   = cur_q.write && (cache_out_data != cur_q.wdata);
`endif
        state_d     = StRsp;
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      rsp_rdata_q <= '0;
`ifdef CACHE_REQ_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef CACHE_REQ_VERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid   = (state_q == StRsp);
  assign rsp_rdata   = rsp_rdata_q;
  assign cache_wr_en = (state_q == StWr);
  assign cache_rd_en = (state_q == StRd);
  assign cache_addr  = (cache_wr_en || cache_rd_en) ? cur_q.addr : '0;
  assign cache_data  = cache_wr_en ? cur_q.wdata : '0;

endmodule

// File: tb/tb_cache_req_master.sv
// Scoreboard bench for cache_req_master with a behavioural 4x8 cache model.
module tb_cache_req_master;

`ifdef CACHE_REQ_VERIFY_EN
  localparam bit Verify = 1'b1;
  localparam int WrLat  = 4;
`else
  localparam bit Verify = 1'b0;
  localparam int WrLat  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       cache_wr_en, cache_rd_en;
  logic [1:0] cache_addr;
  logic [7:0] cache_data, cache_out_data;

  always #5 clk = ~clk;

  cache_req_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .cache_wr_en    (cache_wr_en),
    .cache_rd_en    (cache_rd_en),
    .cache_addr     (cache_addr),
    .cache_data     (cache_data),
    .cache_out_data (cache_out_data)
  );

  // Cache model: registered read, no reset on contents.
  logic [7:0] mem [4];
  logic [7:0] cache_q;
  bit         force_zero = 1'b0;
  always @(posedge clk) begin
    if (cache_wr_en) mem[cache_addr] <= cache_data;
    if (cache_rd_en) cache_q <= force_zero ? 8'h00 : mem[cache_addr];
  end
  assign cache_out_data = cache_q;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  bit         both_seen = 1'b0;
  bit         unstable_seen = 1'b0;
  bit         hold_prev = 1'b0;
  logic [7:0] prev_rdata;
  logic       prev_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every response handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cache_wr_en && cache_rd_en) both_seen = 1'b1;
      if (hold_prev && (!rsp_valid || rsp_rdata !== prev_rdata || rsp_err !== prev_err))
        unstable_seen = 1'b1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h, required no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      hold_prev  = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic [7:0] er, input logic ee, input bit expect_rsp);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 32'(req_ready), 32'd1);
    if (req_ready) begin
      @(posedge clk);
      if (expect_rsp) exp_q.push_back('{rdata: er, err: ee});
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_wr_en"}, 32'(cache_wr_en), 32'd0);
    check({tag, "_rd_en"}, 32'(cache_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(cache_addr), 32'd0);
    check({tag, "_data"}, 32'(cache_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write addr 2 = 0xA5 with exact latency checks.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5;
    @(posedge clk);
    exp_q.push_back('{rdata: 8'hA5, err: 1'b0});
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wr_c1_wr_en", 32'(cache_wr_en), 32'd1);
    check("wr_c1_rd_en", 32'(cache_rd_en), 32'd0);
    check("wr_c1_addr", 32'(cache_addr), 32'd2);
    check("wr_c1_data", 32'(cache_data), 32'hA5);
    for (int c = 2; c <= WrLat; c++) begin
      @(negedge clk);
      check("wr_wr_en_single", 32'(cache_wr_en), 32'd0);
      check("wr_rsp_valid", 32'(rsp_valid), 32'(c == WrLat));
    end
    check("wr_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    @(posedge clk);
    #1;

    // Read addr 2 back.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
    @(posedge clk);
    exp_q.push_back('{rdata: 8'hA5, err: 1'b0});
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rd_c1_rd_en", 32'(cache_rd_en), 32'd1);
    check("rd_c1_wr_en", 32'(cache_wr_en), 32'd0);
    check("rd_c1_addr", 32'(cache_addr), 32'd2);
    @(negedge clk);
    check("rd_c2_rd_en", 32'(cache_rd_en), 32'd0);
    check("rd_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_c3_rdata", 32'(rsp_rdata), 32'hA5);
    @(posedge clk);
    #1;

    // Back-to-back writes then reversed reads.
    send(1'b1, 2'd0, 8'h11, 8'h11, 1'b0, 1'b1);
    send(1'b1, 2'd1, 8'h22, 8'h22, 1'b0, 1'b1);
    send(1'b1, 2'd2, 8'h33, 8'h33, 1'b0, 1'b1);
    send(1'b1, 2'd3, 8'h44, 8'h44, 1'b0, 1'b1);
    send(1'b0, 2'd3, 8'h00, 8'h44, 1'b0, 1'b1);
    send(1'b0, 2'd2, 8'h00, 8'h33, 1'b0, 1'b1);
    send(1'b0, 2'd1, 8'h00, 8'h22, 1'b0, 1'b1);
    send(1'b0, 2'd0, 8'h00, 8'h11, 1'b0, 1'b1);
    drain();

    // Backpressure: one in flight plus two buffered fills the block.
    rsp_ready = 1'b0;
    send(1'b0, 2'd0, 8'h00, 8'h11, 1'b0, 1'b1);
    send(1'b0, 2'd1, 8'h00, 8'h22, 1'b0, 1'b1);
    send(1'b0, 2'd2, 8'h00, 8'h33, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rdata", 32'(rsp_rdata), 32'h11);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(1'b0, 2'd3, 8'h00, 8'h44, 1'b0, 1'b1);
    drain();

    // Reset during RD of a buffered request.
    rsp_ready = 1'b0;
    send(1'b0, 2'd0, 8'h00, 8'h11, 1'b0, 1'b1);
    send(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cache_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_rd_seen", 32'(cache_rd_en), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    check_idle_outputs("midrst_next");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 2'd1, 8'h00, 8'h22, 1'b0, 1'b1);
    drain();

    // Read-back verify path (rsp_err stays 0 without it).
    send(1'b1, 2'd1, 8'h5A, 8'h5A, 1'b0, 1'b1);
    drain();
    force_zero = 1'b1;
    if (Verify) send(1'b1, 2'd2, 8'h77, 8'h00, 1'b1, 1'b1);
    else        send(1'b1, 2'd2, 8'h77, 8'h77, 1'b0, 1'b1);
    drain();
    force_zero = 1'b0;

    check("wr_rd_exclusive", 32'(both_seen), 32'd0);
    check("rsp_stable", 32'(unstable_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
